if_pcgen: RTL

IF_PCGEN -- requirements
Module: if_pcgen

---
 rtl/if_pcgen.sv | 120 ++++++++++++
 1 files changed

// File: rtl/if_pcgen.sv
// rtl/if_pcgen.sv - instruction fetch PC generator with single-outstanding request handshake (option: ADEF_CHECK_EN)
module if_pcgen (
  input  logic        clk,
  input  logic        resetn,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  output logic        inst_req,
  output logic [31:0] inst_addr,
  input  logic        inst_addr_ok,
  input  logic        inst_data_ok,
  input  logic [31:0] inst_rdata,
  input  logic        id_allowin,
  output logic        fs_valid,
  output logic [31:0] fs_pc,
  output logic [31:0] fs_inst,
  output logic        fs_adef
);

  localparam logic [1:0] S_REQ  = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;

  localparam logic [31:0] RESET_PC = 32'h1C00_0000;

  logic [1:0]  state;
  logic [31:0] pc;
  logic        discard;
  // Low for the first cycle after reset release so no request overlaps reset.
  logic        run;
  logic        misaligned;

`ifdef ADEF_CHECK_EN
  assign misaligned = (pc[1:0] != 2'b00);
`else
  assign misaligned = 1'b0;
`endif

  logic in_req;
  logic addr_acc;
  logic adef_take;

  assign in_req    = run && (state == S_REQ);
  assign inst_req  = in_req && !misaligned;
  assign inst_addr = pc;
  assign addr_acc  = inst_req && inst_addr_ok;
  assign adef_take = in_req && misaligned;

  // Fetch FSM: branch redirect outranks every other event in every state.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= S_REQ;
      pc       <= RESET_PC;
      discard  <= 1'b0;
      run      <= 1'b0;
      fs_valid <= 1'b0;
      fs_pc    <= 32'h0;
      fs_inst  <= 32'h0;
      fs_adef  <= 1'b0;
    end else begin
      run <= 1'b1;
      case (state)
        S_REQ: begin
          if (br_taken) begin
            pc <= br_target;
            if (addr_acc) begin
              discard <= 1'b1;
              state   <= S_WAIT;
            end
          end else if (adef_take) begin
            fs_valid <= 1'b1;
            fs_pc    <= pc;
            fs_inst  <= 32'h0;
            fs_adef  <= 1'b1;
            state    <= S_HOLD;
          end else if (addr_acc) begin
            state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (br_taken) begin
            pc <= br_target;
            if (inst_data_ok) begin
              discard <= 1'b0;
              state   <= S_REQ;
            end else begin
              discard <= 1'b1;
            end
          end else if (inst_data_ok) begin
            if (discard) begin
              discard <= 1'b0;
              state   <= S_REQ;
            end else begin
              fs_valid <= 1'b1;
              fs_pc    <= pc;
              fs_inst  <= inst_rdata;
              fs_adef  <= 1'b0;
              state    <= S_HOLD;
            end
          end
        end
        S_HOLD: begin
          if (br_taken) begin
            pc       <= br_target;
            fs_valid <= 1'b0;
            state    <= S_REQ;
          end else if (id_allowin) begin
            pc       <= pc + 32'd4;
            fs_valid <= 1'b0;
            state    <= S_REQ;
          end
        end
        default: begin
          state   <= S_REQ;
          discard <= 1'b0;
        end
      endcase
    end
  end

endmodule
